// File: rtl/alu_pkg.sv
// Shared types and constants for the 8-bit ALU.
// Imported by the interface, the adder/subtractor and the top level.
package alu_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the register file, the ALU and writeback.
// The Zero/Negative/Overflow flags exist only when ALU_FLAGS_EN is defined.
interface alu_if;
  import alu_pkg::*;

  logic [ALU_W-1:0] A;
  logic [ALU_W-1:0] B;
  logic [2:0]       ALU_Sel;
  logic [ALU_W-1:0] ALU_Out;
  logic             CarryOut;

`ifdef ALU_FLAGS_EN
  logic Zero;
  logic Negative;
  logic Overflow;

  modport master (
    output A, B, ALU_Sel,
    input  ALU_Out, CarryOut, Zero, Negative, Overflow
  );

  modport slave (
    input  A, B, ALU_Sel,
    output ALU_Out, CarryOut, Zero, Negative, Overflow
  );
`else
  modport master (
    output A, B, ALU_Sel,
    input  ALU_Out, CarryOut
  );

  modport slave (
    input  A, B, ALU_Sel,
    output ALU_Out, CarryOut
  );
`endif

endinterface

// File: rtl/alu_addsub.sv
// Shared 8-bit adder: subtraction is A + ~B + 1, so sum_o[8] is the raw
// carry (1 = no borrow for SUB). ovf_o is the signed two's-complement overflow.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a_i,
  input  logic [ALU_W-1:0] b_i,
  input  logic             sub_i,
  output logic [ALU_W:0]   sum_o,
  output logic             ovf_o
);

  logic [ALU_W-1:0] b_eff;

  assign b_eff = b_i ^ {ALU_W{sub_i}};
  assign sum_o = {1'b0, a_i} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub_i};

  // Same-sign operands into the adder giving a result of the other sign.
  assign ovf_o = (a_i[ALU_W-1] == b_eff[ALU_W-1]) &&
                 (sum_o[ALU_W-1] != a_i[ALU_W-1]);

endmodule

// File: rtl/alu.sv
// 8-bit registered ALU: op mux over the shared adder and logic/shift ops.
// Optional Zero/Negative/Overflow flags are built when ALU_FLAGS_EN is defined.
module alu
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  alu_op_e          op;
  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] res_d, res_q;
  logic             carry_d, carry_q;

  assign op = alu_op_e'(bus.ALU_Sel);

`ifdef ALU_FLAGS_EN
  logic ovf;
  logic zero_d, zero_q;
  logic neg_d, neg_q;
  logic ovf_d, ovf_q;

  alu_addsub u_addsub (
    .a_i   (bus.A),
    .b_i   (bus.B),
    .sub_i (op == SUB),
    .sum_o (sum),
    .ovf_o (ovf)
  );
`else
  logic ovf_unused;

  alu_addsub u_addsub (
    .a_i   (bus.A),
    .b_i   (bus.B),
    .sub_i (op == SUB),
    .sum_o (sum),
    .ovf_o (ovf_unused)
  );
`endif

  // NOTE: defaults first so every path assigns res_d/carry_d and no latch is inferred.
  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    case (op)
      ADD: begin
        res_d   = sum[ALU_W-1:0];
        carry_d = sum[ALU_W];
      end
      SUB: begin
        res_d   = sum[ALU_W-1:0];
        carry_d = ~sum[ALU_W];
      end
      AND: res_d = bus.A & bus.B;
      OR:  res_d = bus.A | bus.B;
      XOR: res_d = bus.A ^ bus.B;
      NOT: res_d = ~bus.A;
      SHL: begin
        res_d   = {bus.A[ALU_W-2:0], 1'b0};
        carry_d = bus.A[ALU_W-1];
      end
      SHR: begin
        res_d   = {1'b0, bus.A[ALU_W-1:1]};
        carry_d = bus.A[0];
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign bus.ALU_Out  = res_q;
  assign bus.CarryOut = carry_q;

`ifdef ALU_FLAGS_EN
  always_comb begin
    zero_d = (res_d == '0);
    neg_d  = res_d[ALU_W-1];
    ovf_d  = ((op == ADD) || (op == SUB)) ? ovf : 1'b0;
  end

  // Flags clear on reset even though the cleared result is zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.Zero     = zero_q;
  assign bus.Negative = neg_q;
  assign bus.Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, reset/hold sequences,
// and random back-to-back operations against an arithmetic reference model.
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [7:0] out;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    exp_t       e;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_if bus ();

  alu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference computed from the opcode rules with plain integer arithmetic.
  function automatic exp_t model(input int a, input int b, input int sel);
    exp_t e;
    int   r, sa, sb, s;
    e.c = 1'b0;
    e.v = 1'b0;
    sa  = (a > 127) ? a - 256 : a;
    sb  = (b > 127) ? b - 256 : b;
    case (sel)
      0: begin r = a + b; e.c = (r > 255); r = r % 256; s = sa + sb; e.v = (s > 127 || s < -128); end
      1: begin e.c = (a < b); r = (a - b + 256) % 256; s = sa - sb; e.v = (s > 127 || s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; e.c = (a >= 128); end
      default: begin r = a / 2; e.c = (a % 2 == 1); end
    endcase
    e.out = 8'(r);
    e.z   = (r == 0);
    e.n   = (r >= 128);
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input exp_t e);
    check({name, ".out"}, bus.ALU_Out, e.out);
    check({name, ".carry"}, {7'b0, bus.CarryOut}, {7'b0, e.c});
`ifdef ALU_FLAGS_EN
    check({name, ".zero"}, {7'b0, bus.Zero}, {7'b0, e.z});
    check({name, ".neg"}, {7'b0, bus.Negative}, {7'b0, e.n});
    check({name, ".ovf"}, {7'b0, bus.Overflow}, {7'b0, e.v});
`endif
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    @(negedge clk);
    bus.A       = a;
    bus.B       = b;
    bus.ALU_Sel = sel;
  endtask

  task automatic edge_then_sample();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[15];
  exp_t zero_e;
  exp_t e;

  initial begin
    zero_e = '{out: 8'h00, c: 1'b0, z: 1'b0, n: 1'b0, v: 1'b0};

    //                a      b      sel      out    c     z     n     v
    vecs[0]  = '{8'h15, 8'h0A, 3'b000, '{8'h1F, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{8'h15, 8'h0A, 3'b001, '{8'h0B, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{8'h0A, 8'h15, 3'b001, '{8'hF5, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[3]  = '{8'hF0, 8'h0F, 3'b010, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{8'hF0, 8'h0F, 3'b011, '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{8'hFF, 8'h0F, 3'b100, '{8'hF0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{8'hFF, 8'hFF, 3'b000, '{8'hFE, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[7]  = '{8'h7F, 8'h01, 3'b000, '{8'h80, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[8]  = '{8'h81, 8'h00, 3'b110, '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{8'h81, 8'h00, 3'b111, '{8'h40, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{8'h81, 8'h55, 3'b101, '{8'h7E, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{8'h80, 8'h01, 3'b001, '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[12] = '{8'h05, 8'h05, 3'b001, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[13] = '{8'h7F, 8'hAA, 3'b110, '{8'hFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[14] = '{8'h00, 8'hFF, 3'b111, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};

    // Reset with a carry-producing ADD on the inputs: outputs must stay cleared.
    rst         = 1'b1;
    bus.A       = 8'hFF;
    bus.B       = 8'hFF;
    bus.ALU_Sel = 3'b000;
    repeat (3) begin
      edge_then_sample();
      check_outputs("reset_hold", zero_e);
    end
    @(negedge clk);
    rst = 1'b0;
    edge_then_sample();
    check_outputs("reset_release", '{8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});

    // Directed table, one vector per cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sel);
      edge_then_sample();
      check_outputs($sformatf("vec%0d", i), vecs[i].e);
    end

    // Inputs changed between edges must not reach the outputs early.
    drive(8'h15, 8'h0A, 3'b000);
    edge_then_sample();
    bus.A       = 8'hFF;
    bus.B       = 8'h01;
    bus.ALU_Sel = 3'b000;
    @(negedge clk);
    check_outputs("hold_between_edges", '{8'h1F, 1'b0, 1'b0, 1'b0, 1'b0});
    edge_then_sample();
    check_outputs("hold_next_edge", '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

    // Mid-stream reset discards the in-flight result and overrides the op.
    drive(8'h10, 8'h20, 3'b000);
    edge_then_sample();
    check_outputs("pre_reset", '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(8'hFF, 8'hFF, 3'b000);
    rst = 1'b1;
    edge_then_sample();
    check_outputs("midstream_reset", zero_e);
    @(negedge clk);
    rst = 1'b0;
    edge_then_sample();
    check_outputs("post_reset", '{8'hFE, 1'b1, 1'b0, 1'b1, 1'b0});

    // Random back-to-back operations, one per cycle.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] rs;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 3'($urandom_range(0, 7));
      e  = model(int'(ra), int'(rb), int'(rs));
      drive(ra, rb, rs);
      edge_then_sample();
      check_outputs($sformatf("rand%0d_sel%0d_%02h_%02h", i, rs, ra, rb), e);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
